log_divider: RTL and testbench

LOG_DIVIDER -- requirements
Module: log_divider

---
 rtl/log_divider.sv | 122 ++++++++++++
 tb/tb_log_divider.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_divider.sv
// log_divider: 3-stage pipelined Mitchell (logarithmic) approximate divider
module log_divider #(
   parameter int WIDTH_A = 16,
   parameter int WIDTH_B = 16,
   parameter int SIGNED  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_A-1:0] A,
   input  logic [WIDTH_B-1:0] B,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_A-1:0] Q,
   output logic               div_zero
);
   localparam int F  = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
   localparam int XW = F - 1;
   localparam int KW = $clog2(F);
   localparam int DW = KW + XW + 1;
   localparam logic [WIDTH_A-1:0] QMAX = {1'b0, {(WIDTH_A-1){1'b1}}};

   function automatic logic [KW-1:0] lead_one(input logic [F-1:0] m);
      lead_one = '0;
      for (int i = 0; i < F; i++) if (m[i]) lead_one = KW'(i);
   endfunction

   // Bits below the leading one, left-aligned into the fraction field.
   function automatic logic [XW-1:0] frac(input logic [F-1:0] m, input logic [KW-1:0] k);
      logic [F-1:0] t;
      t = m << (KW'(XW) - k);
      frac = t[XW-1:0];
   endfunction

   logic               en;
   logic               a_neg, b_neg;
   logic [WIDTH_A-1:0] mag_a;
   logic [WIDTH_B-1:0] mag_b;
   logic [F-1:0]       ext_a, ext_b;
   logic               v1_q, v1_d, neg1_q, neg1_d, an1_q, an1_d, az1_q, az1_d, bz1_q, bz1_d;
   logic [KW-1:0]      ka_q, ka_d, kb_q, kb_d;
   logic [XW-1:0]      xa_q, xa_d, xb_q, xb_d;
   logic               v2_q, v2_d, neg2_q, neg2_d, an2_q, an2_d, az2_q, az2_d, bz2_q, bz2_d;
   logic [DW-1:0]      diff_q, diff_d;
   logic               v3_q, v3_d, dz_q, dz_d;
   logic [WIDTH_A-1:0] q_q, q_d, res;
   logic [KW-1:0]      kq;
   logic [XW-1:0]      xq;
   logic [2*F-2:0]     sh;
   logic [F-1:0]       mag;

   assign en        = !v3_q | out_ready;
   assign in_ready  = en;
   assign out_valid = v3_q;
   assign Q         = q_q;
   assign div_zero  = dz_q;

   // Operand magnitudes and signs (two's-complement only when SIGNED)
   always_comb begin
      a_neg = (SIGNED != 0) && A[WIDTH_A-1];
      b_neg = (SIGNED != 0) && B[WIDTH_B-1];
      mag_a = a_neg ? -A : A;
      mag_b = b_neg ? -B : B;
      ext_a = F'(mag_a);
      ext_b = F'(mag_b);
   end

   // Stage 1: logarithm (k, x) of each magnitude plus sign and zero flags
   always_comb begin
      v1_d  = en ? in_valid : v1_q;
      ka_d  = en ? lead_one(ext_a) : ka_q;
      kb_d  = en ? lead_one(ext_b) : kb_q;
      xa_d  = en ? frac(ext_a, lead_one(ext_a)) : xa_q;
      xb_d  = en ? frac(ext_b, lead_one(ext_b)) : xb_q;
      neg1_d = en ? a_neg ^ b_neg : neg1_q;
      an1_d = en ? a_neg : an1_q;
      az1_d = en ? (A == '0) : az1_q;
      bz1_d = en ? (B == '0) : bz1_q;
   end

   // Stage 2: log difference, one extra bit so it can go negative without overflow
   always_comb begin
      v2_d   = en ? v1_q : v2_q;
      diff_d = en ? {1'b0, ka_q, xa_q} - {1'b0, kb_q, xb_q} : diff_q;
      neg2_d = en ? neg1_q : neg2_q;
      an2_d  = en ? an1_q : an2_q;
      az2_d  = en ? az1_q : az2_q;
      bz2_d  = en ? bz1_q : bz2_q;
   end

   // Stage 3: antilog, sign, saturation and divide-by-zero substitution
   always_comb begin
      kq   = diff_q[DW-2:XW];
      xq   = diff_q[XW-1:0];
      sh   = (2*F-1)'({1'b1, xq}) << kq;
      mag  = diff_q[DW-1] ? '0 : sh[2*F-2:XW];
      res  = bz2_q ? ((SIGNED != 0) ? (an2_q ? ~QMAX : QMAX) : '1)
           : az2_q ? '0
           : neg2_q ? -mag[WIDTH_A-1:0]
           : ((SIGNED != 0) && (mag > F'(QMAX))) ? QMAX
           : mag[WIDTH_A-1:0];
      v3_d = en ? v2_q : v3_q;
      q_d  = en ? res : q_q;
      dz_d = en ? bz2_q : dz_q;
   end

   // Pipeline registers; everything holds together when the output stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0; ka_q <= '0; kb_q <= '0; xa_q <= '0; xb_q <= '0;
         neg1_q <= 1'b0; an1_q <= 1'b0; az1_q <= 1'b0; bz1_q <= 1'b0;
         v2_q <= 1'b0; diff_q <= '0; neg2_q <= 1'b0; an2_q <= 1'b0; az2_q <= 1'b0; bz2_q <= 1'b0;
         v3_q <= 1'b0; q_q <= '0; dz_q <= 1'b0;
      end else begin
         v1_q <= v1_d; ka_q <= ka_d; kb_q <= kb_d; xa_q <= xa_d; xb_q <= xb_d;
         neg1_q <= neg1_d; an1_q <= an1_d; az1_q <= az1_d; bz1_q <= bz1_d;
         v2_q <= v2_d; diff_q <= diff_d; neg2_q <= neg2_d; an2_q <= an2_d; az2_q <= az2_d; bz2_q <= bz2_d;
         v3_q <= v3_d; q_q <= q_d; dz_q <= dz_d;
      end
   end
endmodule

// File: tb/tb_log_divider.sv
// tb_log_divider: four log_divider variants (u8, s8, u16, s16) on shared stimulus, checked against a behavioural model
module tb_log_divider;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [15:0] A = '0, B = '0;
   logic [3:0] ov, dz, ir;
   logic [7:0] q_u8, q_s8;
   logic [15:0] q_u16, q_s16;
   logic [15:0] qo[4];
   int wid[4] = '{8, 8, 16, 16};
   bit sg[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   int checks = 0, errors = 0;

   typedef struct {logic [15:0] a; logic [15:0] b;} op_t;
   op_t sb[$];

   logic [15:0] ta[4], tb[4], tq[4];
   logic tdz[4];
   logic [15:0] pq, cq, qh;
   logic pd, cd, acc;
   int idx, hold, ma, mb, qm;
   bit started;
   real ex;

   always #5 clk = ~clk;

   assign qo[0] = {8'h00, q_u8};
   assign qo[1] = {8'h00, q_s8};
   assign qo[2] = q_u16;
   assign qo[3] = q_s16;

   log_divider #(.WIDTH_A(8), .WIDTH_B(8), .SIGNED(0)) u_u8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .A(A[7:0]), .B(B[7:0]), .out_valid(ov[0]), .out_ready(out_ready), .Q(q_u8), .div_zero(dz[0]));
   log_divider #(.WIDTH_A(8), .WIDTH_B(8), .SIGNED(1)) u_s8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .A(A[7:0]), .B(B[7:0]), .out_valid(ov[1]), .out_ready(out_ready), .Q(q_s8), .div_zero(dz[1]));
   log_divider #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(0)) u_u16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .A(A), .B(B), .out_valid(ov[2]), .out_ready(out_ready), .Q(q_u16), .div_zero(dz[2]));
   log_divider #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1)) u_s16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
      .A(A), .B(B), .out_valid(ov[3]), .out_ready(out_ready), .Q(q_s16), .div_zero(dz[3]));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Mitchell logarithm: integer part = floor(log2 m), fraction = remaining bits scaled to xw bits
   function automatic longint lg(input longint m, input int xw);
      int k = 0;
      while ((m >> (k + 1)) != 0) k++;
      return (longint'(k) << xw) + ((m - (longint'(1) << k)) << (xw - k));
   endfunction

   // Expected quotient and div_zero for a w-bit divider, from the arithmetic definition
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input int w, input bit sgn,
                                 output logic [15:0] q, output logic d);
      longint one = 1;
      longint mask = (one << w) - 1;
      longint half = one << (w - 1);
      longint av = longint'(a) & mask;
      longint bv = longint'(b) & mask;
      bit an = sgn && (((av >> (w - 1)) & 1) != 0);
      bit bn = sgn && (((bv >> (w - 1)) & 1) != 0);
      longint ma_l = an ? (one << w) - av : av;
      longint mb_l = bn ? (one << w) - bv : bv;
      longint df, mg, r;
      int xw = w - 1;
      d = 1'b0;
      if (bv == 0) begin
         d = 1'b1;
         r = !sgn ? mask : (an ? half : half - 1);
      end else if (ma_l == 0) r = 0;
      else begin
         df = lg(ma_l, xw) - lg(mb_l, xw);
         mg = (df < 0) ? 0 : ((((one << xw) + (df & ((one << xw) - 1))) << (df >> xw)) >> xw);
         r = (an ^ bn) ? (-mg & mask) : ((sgn && mg > half - 1) ? half - 1 : mg);
      end
      q = r[15:0];
   endfunction

   function automatic int absv(input logic [15:0] v, input bit s);
      return (s && v[15]) ? 65536 - int'(v) : int'(v);
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'h0001 << $urandom_range(0, 15);
         2: return 16'h8000;
         3: return 16'($urandom_range(0, 255));
         default: return 16'($urandom());
      endcase
   endfunction

   // Scoreboard: every cycle the output is valid it must match the oldest accepted pair
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_q[%0d]", i), qo[i], 16'd0);
            chk($sformatf("rst_flags[%0d]", i), 16'({ov[i], dz[i], ir[i]}), 16'd1);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("in_ready[%0d]", i), 16'(ir[i]), 16'(!ov[i] | out_ready));
            if (i != 2) chk($sformatf("ov_agree[%0d]", i), 16'(ov[i]), 16'(ov[2]));
         end
         if (ov[2]) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got out_valid with Q=%h, expected no result", qo[2]);
            end else begin
               for (int i = 0; i < 4; i++) begin
                  model(sb[0].a, sb[0].b, wid[i], sg[i], cq, cd);
                  chk($sformatf("q[%0d] a=%h b=%h", i, sb[0].a, sb[0].b), qo[i], cq);
                  chk($sformatf("dz[%0d]", i), 16'(dz[i]), 16'(cd));
                  if (i >= 2 && !cd) begin
                     ma = absv(sb[0].a, sg[i]);
                     mb = absv(sb[0].b, sg[i]);
                     if (mb != 0 && ma >= mb) begin
                        ex = real'(ma) / real'(mb);
                        qm = absv(qo[i], sg[i]);
                        checks++;
                        if ((ex - qm > 0.125 * ex + 1.0) || (qm - ex > 0.125 * ex + 1.0)) begin
                           errors++;
                           $display("FAIL accuracy[%0d]: got %0d, required within 12.5%%+1 of %f", i, qm, ex);
                        end
                     end
                  end
               end
               if (out_ready) void'(sb.pop_front());
            end
         end
         if (in_valid && ir[2]) sb.push_back('{a: A, b: B});
      end
   end

   // Drive n pairs back to back and check exact 3-cycle latency on instance sel
   task automatic burst(input int n, input int sel);
      out_ready = 1'b1;
      for (int i = 0; i < n + 3; i++) begin
         @(posedge clk);
         #1;
         if (i < n) begin
            in_valid = 1'b1;
            A = ta[i];
            B = tb[i];
         end else in_valid = 1'b0;
         if (i < 3) chk($sformatf("latency_ov%0d", i), 16'(ov[sel]), 16'd0);
         else begin
            chk($sformatf("burst_ov%0d", i - 3), 16'(ov[sel]), 16'd1);
            chk($sformatf("burst_q%0d", i - 3), qo[sel], tq[i - 3]);
            chk($sformatf("burst_dz%0d", i - 3), 16'(tdz[i - 3]), 16'(dz[sel]));
         end
      end
   endtask

   initial begin
      model(16'd100, 16'd10, 8, 1'b0, pq, pd);   chk("pin_100_10", pq, 16'd10);
      model(16'd255, 16'd1, 8, 1'b0, pq, pd);    chk("pin_255_1", pq, 16'd255);
      model(16'd7, 16'd9, 8, 1'b0, pq, pd);      chk("pin_7_9", pq, 16'd0);
      model(16'd37, 16'd0, 8, 1'b0, pq, pd);     chk("pin_37_0", {pq[14:0], pd}, {15'h00FF, 1'b1});
      model(16'h00C0, 16'd4, 8, 1'b1, pq, pd);   chk("pin_m64_4", pq, 16'h00F0);
      model(16'h0080, 16'h00FF, 8, 1'b1, pq, pd); chk("pin_m128_m1", pq, 16'h007F);
      model(16'h00FB, 16'd0, 8, 1'b1, pq, pd);   chk("pin_m5_0", {pq[14:0], pd}, {15'h0080, 1'b1});
      model(16'h8000, 16'd2, 16, 1'b0, pq, pd);  chk("pin_pow2_16", pq, 16'h4000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      ta = '{16'd100, 16'd255, 16'd64, 16'd7};
      tb = '{16'd10, 16'd1, 16'd4, 16'd9};
      tq = '{16'd10, 16'd255, 16'd16, 16'd0};
      tdz = '{1'b0, 1'b0, 1'b0, 1'b0};
      burst(4, 0);

      ta[0] = 16'd37; tb[0] = 16'd0; tq[0] = 16'd255; tdz[0] = 1'b1;
      ta[1] = 16'd0;  tb[1] = 16'd5; tq[1] = 16'd0;   tdz[1] = 1'b0;
      burst(2, 0);

      ta = '{16'hFFC0, 16'd64, 16'hFF80, 16'hFFFB};
      tb = '{16'd4, 16'hFFFC, 16'hFFFF, 16'd0};
      tq = '{16'h00F0, 16'h00F0, 16'h007F, 16'h0080};
      tdz = '{1'b0, 1'b0, 1'b0, 1'b1};
      burst(4, 1);

      out_ready = 1'b1;
      idx = 0;
      hold = 0;
      started = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      A = 16'($urandom());
      B = 16'($urandom_range(1, 300));
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         acc = in_valid && ir[2];
         if (hold > 0) begin
            chk("bp_in_ready", 16'(ir[2]), 16'd0);
            chk("bp_ov_held", 16'(ov[2]), 16'd1);
            chk("bp_q_stable", qo[2], qh);
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 6) begin
               A = 16'($urandom());
               B = 16'($urandom_range(1, 300));
            end else in_valid = 1'b0;
         end
         if (hold > 0) begin
            hold--;
            if (hold == 0) out_ready = 1'b1;
         end else if (!started && ov[2]) begin
            started = 1'b1;
            hold = 4;
            out_ready = 1'b0;
            qh = qo[2];
         end
      end
      chk("bp_stalled", 16'(started), 16'd1);
      chk("bp_accepted", 16'(idx), 16'd6);
      chk("bp_drained", 16'(sb.size()), 16'd0);

      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         A = 16'($urandom());
         B = 16'($urandom());
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("rst_mid_ov[%0d]", i), 16'(ov[i]), 16'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      ta[0] = 16'd64; tb[0] = 16'd4; tq[0] = 16'd16; tdz[0] = 1'b0;
      burst(1, 2);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         A = pick();
         B = pick();
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("final_drained", 16'(sb.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
